// File: rtl/redmule_tiler_seq.sv
// RedMulE tiler: derives iteration counts, leftovers, strides and total lengths from M/N/K.
// Products come from one shared shift-add multiplier, one multiplier bit per cycle.
module redmule_tiler_seq #(
    parameter int unsigned ARRAY_WIDTH  = 12,
    parameter int unsigned ARRAY_HEIGHT = 4,
    parameter int unsigned PIPE_REGS    = 3,
    parameter int unsigned DIM_W        = 16,
    parameter int unsigned LEN_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [DIM_W-1:0] m_size_i,
    input  logic [DIM_W-1:0] n_size_i,
    input  logic [DIM_W-1:0] k_size_i,
    input  logic             fmt8_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             error_o,
    output logic [DIM_W-1:0] x_rows_iter_o,
    output logic [DIM_W-1:0] x_cols_iter_o,
    output logic [DIM_W-1:0] w_rows_iter_o,
    output logic [DIM_W-1:0] w_cols_iter_o,
    output logic [7:0]       x_rows_lftovr_o,
    output logic [7:0]       x_cols_lftovr_o,
    output logic [7:0]       w_rows_lftovr_o,
    output logic [7:0]       w_cols_lftovr_o,
    output logic [DIM_W-1:0] tot_stores_o,
    output logic [LEN_W-1:0] tot_x_read_o,
    output logic [LEN_W-1:0] w_tot_len_o,
    output logic [LEN_W-1:0] yz_tot_len_o,
    output logic [LEN_W-1:0] x_d1_stride_o,
    output logic [LEN_W-1:0] x_rows_offs_o,
    output logic [LEN_W-1:0] w_d0_stride_o,
    output logic [LEN_W-1:0] yz_d2_stride_o,
    output logic [LEN_W-1:0] x_buffer_slots_o
);
    localparam int unsigned TILE  = ARRAY_HEIGHT * (PIPE_REGS + 1);
    localparam int unsigned CNT_W = $clog2(DIM_W);

    localparam logic [DIM_W-1:0] AW_D     = DIM_W'(ARRAY_WIDTH);
    localparam logic [DIM_W-1:0] AH_D     = DIM_W'(ARRAY_HEIGHT);
    localparam logic [DIM_W-1:0] AH_M1_D  = DIM_W'(ARRAY_HEIGHT - 1);
    localparam logic [DIM_W-1:0] TILE_D   = DIM_W'(TILE);
    localparam logic [LEN_W-1:0] AW_L     = LEN_W'(ARRAY_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIM_W - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StMul1, StMul2, StDone} state_e;

    typedef struct packed {
        logic [DIM_W-1:0] x_rows_iter;
        logic [DIM_W-1:0] x_cols_iter;
        logic [DIM_W-1:0] w_rows_iter;
        logic [DIM_W-1:0] w_cols_iter;
        logic [7:0]       x_rows_lftovr;
        logic [7:0]       x_cols_lftovr;
        logic [7:0]       w_rows_lftovr;
        logic [7:0]       w_cols_lftovr;
        logic [DIM_W-1:0] tot_stores;
        logic [LEN_W-1:0] tot_x_read;
        logic [LEN_W-1:0] w_tot_len;
        logic [LEN_W-1:0] yz_tot_len;
        logic [LEN_W-1:0] x_d1_stride;
        logic [LEN_W-1:0] x_rows_offs;
        logic [LEN_W-1:0] w_d0_stride;
        logic [LEN_W-1:0] yz_d2_stride;
        logic [LEN_W-1:0] x_buffer_slots;
    } res_t;

    state_e           state_q;
    res_t             res_q, load_res;
    logic             error_q, fmt8_q;
    logic [DIM_W-1:0] m_q, n_q, k_q;
    logic [DIM_W-1:0] mplr_a_q, mplr_b_q;
    logic [LEN_W-1:0] mcand_q, acc_a_q, acc_b_q, p1_q;
    logic [LEN_W-1:0] acc_a_nxt, acc_b_nxt;
    logic [CNT_W-1:0] cnt_q;

    logic [DIM_W-1:0] xr_div, xr_mod, xc_div, xc_mod, wc_div, wc_mod, wr_div, wr_mod;
    logic [LEN_W-1:0] x_d1, w_d0;
    logic             zero_job;

    assign xr_div   = m_q / AW_D;
    assign xr_mod   = m_q % AW_D;
    assign xc_div   = n_q / TILE_D;
    assign xc_mod   = n_q % TILE_D;
    assign wc_div   = k_q / TILE_D;
    assign wc_mod   = k_q % TILE_D;
    assign wr_div   = n_q / AH_D;
    assign wr_mod   = n_q % AH_D;
    assign x_d1     = fmt8_q ? LEN_W'(n_q) : LEN_W'(n_q) << 1;
    assign w_d0     = fmt8_q ? LEN_W'(k_q) : LEN_W'(k_q) << 1;
    assign zero_job = (m_q == '0) || (n_q == '0) || (k_q == '0);

    // Products stay zero here; they are filled in when MUL2 finishes.
    always_comb begin
        load_res = '0;
        if (!zero_job) begin
            load_res.x_rows_iter    = xr_div + DIM_W'(|xr_mod);
            load_res.x_cols_iter    = xc_div + DIM_W'(|xc_mod);
            load_res.w_cols_iter    = wc_div + DIM_W'(|wc_mod);
            load_res.w_rows_iter    = (wr_div + DIM_W'(|wr_mod)) * AH_D;
            load_res.x_rows_lftovr  = xr_mod[7:0];
            load_res.x_cols_lftovr  = xc_mod[7:0];
            load_res.w_cols_lftovr  = wc_mod[7:0];
            load_res.w_rows_lftovr  = wr_mod[7:0];
            load_res.x_d1_stride    = x_d1;
            load_res.w_d0_stride    = w_d0;
            load_res.x_rows_offs    = AW_L * x_d1;
            load_res.yz_d2_stride   = AW_L * w_d0;
            load_res.x_buffer_slots = LEN_W'(((xc_mod + AH_M1_D) / AH_D) * AH_D);
        end
    end

    assign acc_a_nxt = acc_a_q + (mplr_a_q[0] ? mcand_q : '0);
    assign acc_b_nxt = acc_b_q + (mplr_b_q[0] ? mcand_q : '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            res_q    <= '0;
            error_q  <= 1'b0;
            fmt8_q   <= 1'b0;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            mplr_a_q <= '0;
            mplr_b_q <= '0;
            mcand_q  <= '0;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            p1_q     <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            state_q <= StIdle;
            res_q   <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        m_q     <= m_size_i;
                        n_q     <= n_size_i;
                        k_q     <= k_size_i;
                        fmt8_q  <= fmt8_i;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    res_q    <= load_res;
                    error_q  <= zero_job;
                    mcand_q  <= LEN_W'(load_res.x_rows_iter);
                    mplr_a_q <= load_res.w_cols_iter;
                    acc_a_q  <= '0;
                    cnt_q    <= '0;
                    state_q  <= zero_job ? StDone : StMul1;
                end
                StMul1: begin
                    mcand_q  <= mcand_q << 1;
                    mplr_a_q <= mplr_a_q >> 1;
                    acc_a_q  <= acc_a_nxt;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // P1 seeds the shared multiplicand; both MUL2 factors come from the iters.
                    if (cnt_q == CNT_LAST) begin
                        p1_q     <= acc_a_nxt;
                        mcand_q  <= acc_a_nxt;
                        mplr_a_q <= res_q.x_cols_iter;
                        mplr_b_q <= res_q.w_rows_iter;
                        acc_a_q  <= '0;
                        acc_b_q  <= '0;
                        cnt_q    <= '0;
                        state_q  <= StMul2;
                    end
                end
                StMul2: begin
                    mcand_q  <= mcand_q << 1;
                    mplr_a_q <= mplr_a_q >> 1;
                    mplr_b_q <= mplr_b_q >> 1;
                    acc_a_q  <= acc_a_nxt;
                    acc_b_q  <= acc_b_nxt;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        res_q.tot_x_read <= acc_a_nxt;
                        res_q.w_tot_len  <= acc_b_nxt;
                        res_q.yz_tot_len <= AW_L * p1_q;
                        res_q.tot_stores <= p1_q[DIM_W-1:0];
                        cnt_q            <= '0;
                        state_q          <= StDone;
                    end
                end
                StDone: begin
                    if (ready_i) begin
                        error_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o          = (state_q == StIdle);
    assign valid_o          = (state_q == StDone);
    assign error_o          = error_q;
    assign x_rows_iter_o    = res_q.x_rows_iter;
    assign x_cols_iter_o    = res_q.x_cols_iter;
    assign w_rows_iter_o    = res_q.w_rows_iter;
    assign w_cols_iter_o    = res_q.w_cols_iter;
    assign x_rows_lftovr_o  = res_q.x_rows_lftovr;
    assign x_cols_lftovr_o  = res_q.x_cols_lftovr;
    assign w_rows_lftovr_o  = res_q.w_rows_lftovr;
    assign w_cols_lftovr_o  = res_q.w_cols_lftovr;
    assign tot_stores_o     = res_q.tot_stores;
    assign tot_x_read_o     = res_q.tot_x_read;
    assign w_tot_len_o      = res_q.w_tot_len;
    assign yz_tot_len_o     = res_q.yz_tot_len;
    assign x_d1_stride_o    = res_q.x_d1_stride;
    assign x_rows_offs_o    = res_q.x_rows_offs;
    assign w_d0_stride_o    = res_q.w_d0_stride;
    assign yz_d2_stride_o   = res_q.yz_d2_stride;
    assign x_buffer_slots_o = res_q.x_buffer_slots;

endmodule

// File: tb/tb_redmule_tiler_seq.sv
// Directed-vector bench for redmule_tiler_seq at default parameters (TILE = 16).
module tb_redmule_tiler_seq;
    localparam int unsigned DIM_W = 16;
    localparam int unsigned LEN_W = 32;

    logic             clk_i = 1'b0;
    logic             rst_i, clear_i, start_i, fmt8_i, ready_i;
    logic [DIM_W-1:0] m_size_i, n_size_i, k_size_i;
    logic             ready_o, valid_o, error_o;
    logic [DIM_W-1:0] x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o, tot_stores_o;
    logic [7:0]       x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o;
    logic [LEN_W-1:0] tot_x_read_o, w_tot_len_o, yz_tot_len_o, x_d1_stride_o, x_rows_offs_o;
    logic [LEN_W-1:0] w_d0_stride_o, yz_d2_stride_o, x_buffer_slots_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    redmule_tiler_seq dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clear_i         (clear_i),
        .start_i         (start_i),
        .m_size_i        (m_size_i),
        .n_size_i        (n_size_i),
        .k_size_i        (k_size_i),
        .fmt8_i          (fmt8_i),
        .ready_o         (ready_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .error_o         (error_o),
        .x_rows_iter_o   (x_rows_iter_o),
        .x_cols_iter_o   (x_cols_iter_o),
        .w_rows_iter_o   (w_rows_iter_o),
        .w_cols_iter_o   (w_cols_iter_o),
        .x_rows_lftovr_o (x_rows_lftovr_o),
        .x_cols_lftovr_o (x_cols_lftovr_o),
        .w_rows_lftovr_o (w_rows_lftovr_o),
        .w_cols_lftovr_o (w_cols_lftovr_o),
        .tot_stores_o    (tot_stores_o),
        .tot_x_read_o    (tot_x_read_o),
        .w_tot_len_o     (w_tot_len_o),
        .yz_tot_len_o    (yz_tot_len_o),
        .x_d1_stride_o   (x_d1_stride_o),
        .x_rows_offs_o   (x_rows_offs_o),
        .w_d0_stride_o   (w_d0_stride_o),
        .yz_d2_stride_o  (yz_d2_stride_o),
        .x_buffer_slots_o(x_buffer_slots_o)
    );

    typedef struct {
        logic [15:0] m, n, k;
        logic        fmt8, err;
        int          lat;
        logic [15:0] xri, xci, wri, wci;
        logic [7:0]  xrl, xcl, wrl, wcl;
        logic [15:0] st;
        logic [31:0] txr, wtl, yzl, xd1, xro, wd0, yzd2, slots;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_job(input vec_t v);
        @(negedge clk_i);
        m_size_i = v.m;
        n_size_i = v.n;
        k_size_i = v.k;
        fmt8_i   = v.fmt8;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk_i);
            #1 lat++;
        end
    endtask

    task automatic check_res(input vec_t v, input string t);
        check({t, ".valid"}, 64'(valid_o), 64'(1'b1));
        check({t, ".error"}, 64'(error_o), 64'(v.err));
        check({t, ".xri"}, 64'(x_rows_iter_o), 64'(v.xri));
        check({t, ".xci"}, 64'(x_cols_iter_o), 64'(v.xci));
        check({t, ".wri"}, 64'(w_rows_iter_o), 64'(v.wri));
        check({t, ".wci"}, 64'(w_cols_iter_o), 64'(v.wci));
        check({t, ".xrl"}, 64'(x_rows_lftovr_o), 64'(v.xrl));
        check({t, ".xcl"}, 64'(x_cols_lftovr_o), 64'(v.xcl));
        check({t, ".wrl"}, 64'(w_rows_lftovr_o), 64'(v.wrl));
        check({t, ".wcl"}, 64'(w_cols_lftovr_o), 64'(v.wcl));
        check({t, ".stores"}, 64'(tot_stores_o), 64'(v.st));
        check({t, ".txr"}, 64'(tot_x_read_o), 64'(v.txr));
        check({t, ".wtl"}, 64'(w_tot_len_o), 64'(v.wtl));
        check({t, ".yzl"}, 64'(yz_tot_len_o), 64'(v.yzl));
        check({t, ".xd1"}, 64'(x_d1_stride_o), 64'(v.xd1));
        check({t, ".xro"}, 64'(x_rows_offs_o), 64'(v.xro));
        check({t, ".wd0"}, 64'(w_d0_stride_o), 64'(v.wd0));
        check({t, ".yzd2"}, 64'(yz_d2_stride_o), 64'(v.yzd2));
        check({t, ".slots"}, 64'(x_buffer_slots_o), 64'(v.slots));
    endtask

    task automatic handshake(input vec_t v, input string t);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1 ready_i = 1'b0;
        check({t, ".hs_valid"}, 64'(valid_o), 64'(1'b0));
        check({t, ".hs_error"}, 64'(error_o), 64'(1'b0));
        check({t, ".hs_ready"}, 64'(ready_o), 64'(1'b1));
        check({t, ".hs_txr_kept"}, 64'(tot_x_read_o), 64'(v.txr));
        check({t, ".hs_xri_kept"}, 64'(x_rows_iter_o), 64'(v.xri));
    endtask

    initial begin
        int lat;
        //        m       n       k      f8    err  lat xri   xci   wri    wci
        //        xrl  xcl  wrl  wcl  stores txr  wtl  yzl  xd1  xro  wd0  yzd2 slots
        vecs[0] = '{16'd24, 16'd32, 16'd32, 1'b0, 1'b0, 33, 16'd2, 16'd2, 16'd32, 16'd2,
                    8'd0, 8'd0, 8'd0, 8'd0, 16'd4, 32'd8, 32'd128, 32'd48,
                    32'd64, 32'd768, 32'd64, 32'd768, 32'd0};
        vecs[1] = '{16'd13, 16'd17, 16'd20, 1'b1, 1'b0, 33, 16'd2, 16'd2, 16'd20, 16'd2,
                    8'd1, 8'd1, 8'd1, 8'd4, 16'd4, 32'd8, 32'd80, 32'd48,
                    32'd17, 32'd204, 32'd20, 32'd240, 32'd4};
        vecs[2] = '{16'd100, 16'd50, 16'd7, 1'b0, 1'b0, 33, 16'd9, 16'd4, 16'd52, 16'd1,
                    8'd4, 8'd2, 8'd2, 8'd7, 16'd9, 32'd36, 32'd468, 32'd108,
                    32'd100, 32'd1200, 32'd14, 32'd168, 32'd4};
        vecs[3] = '{16'd1, 16'd1, 16'd1, 1'b1, 1'b0, 33, 16'd1, 16'd1, 16'd4, 16'd1,
                    8'd1, 8'd1, 8'd1, 8'd1, 16'd1, 32'd1, 32'd4, 32'd12,
                    32'd1, 32'd12, 32'd1, 32'd12, 32'd4};
        vecs[4] = '{16'd11, 16'd15, 16'd31, 1'b1, 1'b0, 33, 16'd1, 16'd1, 16'd16, 16'd2,
                    8'd11, 8'd15, 8'd3, 8'd15, 16'd2, 32'd2, 32'd32, 32'd24,
                    32'd15, 32'd180, 32'd31, 32'd372, 32'd16};
        // Products wrap modulo 2^32 and tot_stores modulo 2^16.
        vecs[5] = '{16'd60000, 16'd40000, 16'd50000, 1'b0, 1'b0, 33,
                    16'd5000, 16'd2500, 16'd40000, 16'd3125,
                    8'd0, 8'd0, 8'd0, 8'd0, 16'd27432, 32'd407794336, 32'd2229742080,
                    32'd187500000, 32'd80000, 32'd960000, 32'd100000, 32'd1200000, 32'd0};
        vecs[6] = '{16'd24, 16'd32, 16'd0, 1'b0, 1'b1, 1, 16'd0, 16'd0, 16'd0, 16'd0,
                    8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 32'd0, 32'd0, 32'd0,
                    32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[7] = '{16'd0, 16'd5, 16'd5, 1'b1, 1'b1, 1, 16'd0, 16'd0, 16'd0, 16'd0,
                    8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 32'd0, 32'd0, 32'd0,
                    32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b0; fmt8_i = 1'b0;
        m_size_i = '0; n_size_i = '0; k_size_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst.ready", 64'(ready_o), 64'(1'b1));
        check("rst.valid", 64'(valid_o), 64'(1'b0));
        check("rst.error", 64'(error_o), 64'(1'b0));
        check("rst.xri", 64'(x_rows_iter_o), 64'd0);
        check("rst.txr", 64'(tot_x_read_o), 64'd0);
        check("rst.slots", 64'(x_buffer_slots_o), 64'd0);
        @(negedge clk_i) rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            check({t, ".ready_pre"}, 64'(ready_o), 64'(1'b1));
            start_job(vecs[i]);
            wait_valid(lat);
            check({t, ".latency"}, 64'(lat), 64'(vecs[i].lat));
            check_res(vecs[i], t);
            handshake(vecs[i], t);
        end

        // Backpressure, plus a start pulse with different sizes during MUL1.
        start_job(vecs[0]);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("busy.ready", 64'(ready_o), 64'(1'b0));
        m_size_i = 16'd1; n_size_i = 16'd1; k_size_i = 16'd1; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        wait_valid(lat);
        check("busy.latency", 64'(lat), 64'd28);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i);
            #1;
            check("bp.valid_held", 64'(valid_o), 64'(1'b1));
            check("bp.wtl_stable", 64'(w_tot_len_o), 64'(vecs[0].wtl));
        end
        check_res(vecs[0], "bp");
        handshake(vecs[0], "bp");

        // clear_i in MUL2 with start_i and ready_i also high.
        start_job(vecs[2]);
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        clear_i = 1'b1; start_i = 1'b1; ready_i = 1'b1;
        m_size_i = vecs[0].m; n_size_i = vecs[0].n; k_size_i = vecs[0].k;
        @(posedge clk_i);
        #1 clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
        check("clr.ready", 64'(ready_o), 64'(1'b1));
        check("clr.valid", 64'(valid_o), 64'(1'b0));
        check("clr.xri", 64'(x_rows_iter_o), 64'd0);
        check("clr.xd1", 64'(x_d1_stride_o), 64'd0);
        check("clr.slots", 64'(x_buffer_slots_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("clr.no_start", 64'(ready_o), 64'(1'b1));
        check("clr.xri_still0", 64'(x_rows_iter_o), 64'd0);

        // Asynchronous reset mid-MUL1.
        start_job(vecs[0]);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("arst.ready", 64'(ready_o), 64'(1'b1));
        check("arst.valid", 64'(valid_o), 64'(1'b0));
        check("arst.xri", 64'(x_rows_iter_o), 64'd0);
        check("arst.xd1", 64'(x_d1_stride_o), 64'd0);
        check("arst.xro", 64'(x_rows_offs_o), 64'd0);
        @(negedge clk_i) rst_i = 1'b0;

        // Back-to-back: second start in the cycle right after the handshake.
        start_job(vecs[1]);
        wait_valid(lat);
        check("b2b.lat1", 64'(lat), 64'd33);
        check_res(vecs[1], "b2b1");
        @(negedge clk_i) ready_i = 1'b1;
        @(posedge clk_i);
        #1 ready_i = 1'b0;
        check("b2b.hs_valid", 64'(valid_o), 64'(1'b0));
        check("b2b.hs_ready", 64'(ready_o), 64'(1'b1));
        start_job(vecs[3]);
        check("b2b.accepted", 64'(ready_o), 64'(1'b0));
        check("b2b.valid_low", 64'(valid_o), 64'(1'b0));
        wait_valid(lat);
        check("b2b.lat2", 64'(lat), 64'd33);
        check_res(vecs[3], "b2b2");
        handshake(vecs[3], "b2b2");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/redmule_tiler_seq.md
Name: redmule_tiler_seq

Overview:
Parametrised successor of the RedMulE tiler. It takes the GEMM sizes M/N/K and an element-width mode, and computes the iteration counts, leftovers, total lengths and byte strides that the streamer and scheduler need. Products are computed with one internal shift-add multiplier FSM instead of chained external multipliers. Results are presented through a valid/ready handshake, and zero-size jobs are detected. It sits between the register file and the controller/streamer configuration path.

Parameters:
ARRAY_WIDTH, 12, CE array rows; row tile size for M
ARRAY_HEIGHT, 4, CE array columns; W-row granularity and X buffer slot granularity
PIPE_REGS, 3, CE pipeline registers; TILE = ARRAY_HEIGHT*(PIPE_REGS+1)
DIM_W, 16, width of the size inputs and of the iteration outputs
LEN_W, 32, width of the length, stride and product outputs

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
clear_i  in  1  synchronous soft clear
start_i  in  1  start request; accepted only when ready_o=1
m_size_i  in  DIM_W  M (X rows)
n_size_i  in  DIM_W  N (X cols = W rows)
k_size_i  in  DIM_W  K (W cols)
fmt8_i  in  1  1 = 8-bit elements (1 B), 0 = 16-bit elements (2 B)
ready_o  out  1  idle, can accept start_i
valid_o  out  1  results valid
ready_i  in  1  consumer accepts results
error_o  out  1  zero-size job; qualified by valid_o
x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o  out  DIM_W each  iteration counts
x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o  out  8 each  leftovers
tot_stores_o  out  DIM_W  x_rows_iter*w_cols_iter, truncated
tot_x_read_o, w_tot_len_o, yz_tot_len_o  out  LEN_W each  total lengths
x_d1_stride_o, x_rows_offs_o, w_d0_stride_o, yz_d2_stride_o, x_buffer_slots_o  out  LEN_W each  strides/slots

Behaviour:
- Reset (rst_i=1, async): state IDLE; ready_o=1; valid_o=0; error_o=0; every result output 0.
- clear_i: next edge forces IDLE and zeroes all outputs. clear_i beats start_i and ready_i in the same cycle.
- FSM states: IDLE -> LOAD -> MUL1 -> MUL2 -> DONE -> IDLE.
  - IDLE: ready_o=1. start_i=1 latches the sizes and fmt8_i, then goes to LOAD. In every other state start_i is ignored and ready_o=0.
  - LOAD (1 cycle): registers the derived values below.
    - x_rows_iter = ceil(M/ARRAY_WIDTH); x_rows_lftovr = M mod ARRAY_WIDTH.
    - x_cols_iter = ceil(N/TILE); x_cols_lftovr = N mod TILE.
    - w_cols_iter = ceil(K/TILE); w_cols_lftovr = K mod TILE.
    - w_rows_lftovr = N mod ARRAY_HEIGHT; w_rows_iter = N rounded up to a multiple of ARRAY_HEIGHT.
    - EB = fmt8 ? 1 : 2; x_d1_stride = N*EB; w_d0_stride = K*EB.
    - x_rows_offs = ARRAY_WIDTH*x_d1_stride; yz_d2_stride = ARRAY_WIDTH*w_d0_stride.
    - x_buffer_slots = ceil(x_cols_lftovr/ARRAY_HEIGHT)*ARRAY_HEIGHT.
    - Divisions and mods are by elaboration constants and are combinational.
    - If M, N or K is 0: all results set to 0, error_o=1, go straight to DONE.
  - MUL1 (DIM_W cycles): shift-add, 1 multiplier bit per cycle, P1 = x_rows_iter*w_cols_iter.
  - MUL2 (DIM_W cycles): two accumulators share the multiplier bit stream.
    - Pa = x_cols_iter*P1; Pb = w_rows_iter*P1.
    - On exit: tot_x_read = Pa[LEN_W-1:0], w_tot_len = Pb[LEN_W-1:0], yz_tot_len = ARRAY_WIDTH*P1, tot_stores = P1[DIM_W-1:0].
  - DONE: valid_o=1 and outputs held stable until ready_i=1. The edge with valid_o&&ready_i goes to IDLE.
- Latency: valid_o rises 2*DIM_W+1 edges after the accepting edge (33 at default); the error path takes 1 edge.
- After the handshake, result outputs keep their values until the next LOAD; valid_o=0, error_o cleared.
- Width rules:
  - All products are truncated modulo 2^LEN_W; there is no overflow flag.
  - Leftover outputs are truncated to 8 bits; parameters must keep TILE and ARRAY_WIDTH at 128 or less.
- Reset mid-operation aborts immediately to the reset state. A pending valid_o is not preserved.

Test Plan:
- Aligned case, default params, M=24 N=32 K=32 fp16 -> after 33 cycles: valid_o=1, error_o=0, x_rows_iter=2, x_cols_iter=2, w_cols_iter=2, w_rows_iter=32, all leftovers 0, tot_stores=4, tot_x_read=8, w_tot_len=128, yz_tot_len=48, x_d1_stride=64, w_d0_stride=64, x_rows_offs=768, yz_d2_stride=768, x_buffer_slots=0.
- Leftover case, M=13 N=17 K=20 fp8 -> iters x_rows=2, x_cols=2, w_cols=2, w_rows=20; leftovers 1/1/1/4; tot_stores=4, tot_x_read=8, w_tot_len=80, yz_tot_len=48, x_d1_stride=17, w_d0_stride=20, x_buffer_slots=4.
- Zero size, K=0 -> valid_o and error_o both 1, 2 edges after start; all results 0; handshake returns to IDLE.
- Backpressure and busy start: hold ready_i=0 for 10 cycles in DONE -> outputs stable, valid_o held. start_i pulsed during MUL1 -> ignored, results unchanged.
- clear_i during MUL2, with start_i high in the same cycle -> IDLE, outputs 0, start not accepted. rst_i asserted mid-MUL1 -> outputs 0 asynchronously.
- Back-to-back jobs: start asserted the cycle after the handshake -> accepted; second job's results correct; valid_o not re-asserted for the first job.
